trap_sequencer: RTL and testbench

Trap and return sequencer for the RV32 core. It sits directly upstream of the CSR register file and owns that file's single access port (number / access type / write data / read data). It also muxes instruction-driven CSR accesses from the decoder onto that port. On an exception it writes mepc and mcause, reads mtvec, and issues a PC redirect. On mret it reads mepc and redirects.

---
 rtl/csr_pkg.sv | 11 +
 rtl/trap_pkg.sv | 30 +++
 rtl/trap_csr_port_mux.sv | 19 +
 rtl/trap_sequencer.sv | 157 +++++++++++++++
 tb/tb_trap_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR access-type encoding used by the CSR register file port
package csr_pkg;

    typedef enum logic [1:0] {
        READ_ONLY = 2'b00,
        WRITE     = 2'b01,
        SET       = 2'b10,
        CLEAR     = 2'b11
    } csr_access_t;

endpackage

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - trap sequencer states, machine CSR numbers and cause codes (TVAL_WR only with TRAP_MTVAL_EN)
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EPC_WR   = 3'd1,
        CAUSE_WR = 3'd2,
`ifdef TRAP_MTVAL_EN
        TVAL_WR  = 3'd3,
`endif
        TVEC_RD  = 3'd4,
        EPC_RD   = 3'd5,
        DONE     = 3'd6
    } trap_state_t;

    localparam logic [11:0] MEPC   = 12'h341;
    localparam logic [11:0] MCAUSE = 12'h342;
    localparam logic [11:0] MTVAL  = 12'h343;
    localparam logic [11:0] MTVEC  = 12'h305;

    localparam logic [3:0] CAUSE_ILLEGAL_INSTR = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT    = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M       = 4'd11;

    // Both mepc and trap targets are word aligned; the low bits are never honoured.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_csr_port_mux.sv
// rtl/trap_csr_port_mux.sv - selects decoder or sequencer access onto the single CSR file port
module trap_csr_port_mux (
    input  logic        sel_ins,
    input  logic [11:0] ins_number,
    input  logic [1:0]  ins_access_type,
    input  logic [31:0] ins_wdata,
    input  logic [11:0] fsm_number,
    input  logic [1:0]  fsm_access_type,
    input  logic [31:0] fsm_wdata,
    output logic [11:0] csr_number,
    output logic [1:0]  csr_access_type,
    output logic [31:0] csr_wdata
);

    assign csr_number      = sel_ins ? ins_number      : fsm_number;
    assign csr_access_type = sel_ins ? ins_access_type : fsm_access_type;
    assign csr_wdata       = sel_ins ? ins_wdata       : fsm_wdata;

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - exception/mret sequencer owning the CSR file port; TRAP_MTVAL_EN adds the mtval write
module trap_sequencer
    import trap_pkg::*;
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        trap_req,
    input  logic [3:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret_req,
    input  logic        ins_valid,
    input  logic [11:0] ins_number,
    input  logic [1:0]  ins_access_type,
    input  logic [31:0] ins_wdata,
    output logic        ins_ready,
    output logic [31:0] ins_rdata,
    output logic [11:0] csr_number,
    output logic [1:0]  csr_access_type,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    trap_state_t state;
    trap_state_t state_nxt;

    logic [3:0]  cause_q;
    logic [31:0] pc_q;
`ifdef TRAP_MTVAL_EN
    logic [31:0] val_q;
`else
    logic        unused_trap_val;
    assign unused_trap_val = ^trap_val;
`endif

    logic [11:0] fsm_number;
    csr_access_t fsm_access_type;
    logic [31:0] fsm_wdata;
    logic        load_redirect;
    logic        pass_through;

    // Decoder only owns the port in a quiet IDLE cycle; a pending trap/mret takes it away.
    assign pass_through = !reset && (state == IDLE) && !trap_req && !mret_req;
    assign ins_ready    = pass_through && ins_valid;
    assign ins_rdata    = csr_rdata;

    assign busy           = (state != IDLE);
    assign redirect_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cause_q     <= 4'd0;
            pc_q        <= 32'd0;
`ifdef TRAP_MTVAL_EN
            val_q       <= 32'd0;
`endif
            redirect_pc <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && trap_req) begin
                cause_q <= trap_cause;
                pc_q    <= trap_pc;
`ifdef TRAP_MTVAL_EN
                val_q   <= trap_val;
`endif
            end
            if (load_redirect) begin
                redirect_pc <= align_word(csr_rdata);
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        fsm_number      = 12'h000;
        fsm_access_type = READ_ONLY;
        fsm_wdata       = 32'd0;
        load_redirect   = 1'b0;

        case (state)
            IDLE: begin
                if (trap_req) begin
                    state_nxt = EPC_WR;
                end else if (mret_req) begin
                    state_nxt = EPC_RD;
                end
            end
            EPC_WR: begin
                fsm_number      = MEPC;
                fsm_access_type = WRITE;
                fsm_wdata       = align_word(pc_q);
                state_nxt       = CAUSE_WR;
            end
            CAUSE_WR: begin
                fsm_number      = MCAUSE;
                fsm_access_type = WRITE;
                fsm_wdata       = {28'd0, cause_q};
`ifdef TRAP_MTVAL_EN
                state_nxt       = TVAL_WR;
`else
                state_nxt       = TVEC_RD;
`endif
            end
`ifdef TRAP_MTVAL_EN
            TVAL_WR: begin
                fsm_number      = MTVAL;
                fsm_access_type = WRITE;
                fsm_wdata       = val_q;
                state_nxt       = TVEC_RD;
            end
`endif
            // Mode bits of mtvec are dropped, so vectored mode lands on the base like direct mode.
            TVEC_RD: begin
                fsm_number    = MTVEC;
                load_redirect = 1'b1;
                state_nxt     = DONE;
            end
            EPC_RD: begin
                fsm_number    = MEPC;
                load_redirect = 1'b1;
                state_nxt     = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A write in flight when reset lands is abandoned rather than completed.
        if (reset) begin
            fsm_number      = 12'h000;
            fsm_access_type = READ_ONLY;
            fsm_wdata       = 32'd0;
        end
    end

    trap_csr_port_mux u_port_mux (
        .sel_ins         (ins_ready),
        .ins_number      (ins_number),
        .ins_access_type (ins_access_type),
        .ins_wdata       (ins_wdata),
        .fsm_number      (fsm_number),
        .fsm_access_type (fsm_access_type),
        .fsm_wdata       (fsm_wdata),
        .csr_number      (csr_number),
        .csr_access_type (csr_access_type),
        .csr_wdata       (csr_wdata)
    );

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed and randomized checks of trap_sequencer against a CSR-level reference model
module tb_trap_sequencer;
    import trap_pkg::*;
    import csr_pkg::*;

`ifdef TRAP_MTVAL_EN
    localparam int TRAP_LAT = 5;
`else
    localparam int TRAP_LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        trap_req;
    logic [3:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret_req;
    logic        ins_valid;
    logic [11:0] ins_number;
    logic [1:0]  ins_access_type;
    logic [31:0] ins_wdata;
    logic        ins_ready;
    logic [31:0] ins_rdata;
    logic [11:0] csr_number;
    logic [1:0]  csr_access_type;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trap_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .trap_req        (trap_req),
        .trap_cause      (trap_cause),
        .trap_pc         (trap_pc),
        .trap_val        (trap_val),
        .mret_req        (mret_req),
        .ins_valid       (ins_valid),
        .ins_number      (ins_number),
        .ins_access_type (ins_access_type),
        .ins_wdata       (ins_wdata),
        .ins_ready       (ins_ready),
        .ins_rdata       (ins_rdata),
        .csr_number      (csr_number),
        .csr_access_type (csr_access_type),
        .csr_wdata       (csr_wdata),
        .csr_rdata       (csr_rdata),
        .busy            (busy),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    // Stand-in CSR register file: combinational read, write on the edge, not cleared by core reset.
    logic [31:0] env_csr [0:4095];
    logic        env_clear;
    assign csr_rdata = env_csr[csr_number];

    always @(posedge clk) begin
        if (env_clear) begin
            for (int i = 0; i < 4096; i++) env_csr[i] <= 32'd0;
        end else begin
            case (csr_access_type)
                2'b01:   env_csr[csr_number] <= csr_wdata;
                2'b10:   env_csr[csr_number] <= env_csr[csr_number] | csr_wdata;
                2'b11:   env_csr[csr_number] <= env_csr[csr_number] & ~csr_wdata;
                default: ;
            endcase
        end
    end

    // Reference view of architectural CSR contents, updated from the access rules alone.
    logic [31:0] ref_csr [0:4095];
    logic [11:0] csr_pool [0:5];

    function automatic logic [31:0] apply_op(input logic [31:0] old, input logic [1:0] t,
                                             input logic [31:0] d);
        if (t == 2'd1) return d;
        if (t == 2'd2) return old | d;
        if (t == 2'd3) return old & ~d;
        return old;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_ins(input logic [11:0] num, input logic [1:0] t, input logic [31:0] d);
        ins_valid = 1'b1;
        ins_number = num;
        ins_access_type = t;
        ins_wdata = d;
        #1;
        check("ins_ready", ins_ready, 1);
        check("ins_rdata_old", ins_rdata, ref_csr[num]);
        ref_csr[num] = apply_op(ref_csr[num], t, d);
        @(negedge clk);
        ins_valid = 1'b0;
        ins_access_type = 2'd0;
        #1;
        check("ins_csr_after", env_csr[num], ref_csr[num]);
    endtask

    task automatic do_trap(input logic [31:0] pc, input logic [3:0] cause, input logic [31:0] val,
                           input bit with_mret, input bit with_ins, input bit poke_done);
        logic [31:0] exp_pc;
        int k;
        bit seen;
        trap_req = 1'b1;
        trap_pc = pc;
        trap_cause = cause;
        trap_val = val;
        mret_req = with_mret;
        if (with_ins) begin
            ins_valid = 1'b1;
            ins_number = MTVEC;
            ins_access_type = 2'd1;
            ins_wdata = 32'hFFFF_FFFF;
        end
        #1;
        check("trap_accept_ins_ready", ins_ready, 0);
        check("trap_accept_busy", busy, 0);
        ref_csr[MEPC] = pc & 32'hFFFF_FFFC;
        ref_csr[MCAUSE] = 32'(cause);
`ifdef TRAP_MTVAL_EN
        ref_csr[MTVAL] = val;
`endif
        exp_pc = ref_csr[MTVEC] & 32'hFFFF_FFFC;
        @(negedge clk);
        trap_req = 1'b0;
        mret_req = 1'b0;
        ins_valid = 1'b0;
        ins_access_type = 2'd0;
        trap_pc = $urandom;
        trap_cause = 4'($urandom);
        trap_val = $urandom;
        seen = 1'b0;
        k = 1;
        while (!seen && k <= 12) begin
            #1;
            if (k == 2) check("mepc_visible_c2", env_csr[MEPC], ref_csr[MEPC]);
`ifdef TRAP_MTVAL_EN
            if (k == 3) begin
                check("mtval_num_c3", 32'(csr_number), 32'(MTVAL));
                check("mtval_type_c3", 32'(csr_access_type), 32'd1);
                check("mtval_data_c3", csr_wdata, val);
            end
`else
            if (k == 3) begin
                check("mtvec_num_c3", 32'(csr_number), 32'(MTVEC));
                check("mtvec_type_c3", 32'(csr_access_type), 32'd0);
            end
`endif
            check("trap_busy", busy, 1);
            if (redirect_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("trap_redirect_cycle", k, TRAP_LAT);
        check("trap_redirect_pc", redirect_pc, exp_pc);
        check("trap_mcause", env_csr[MCAUSE], ref_csr[MCAUSE]);
        if (poke_done) begin
            trap_req = 1'b1;
            trap_pc = 32'h5555_0000;
        end
        @(negedge clk);
        trap_req = 1'b0;
        #1;
        check("trap_idle_busy", busy, 0);
        check("trap_idle_redirect", redirect_valid, 0);
        @(negedge clk);
        #1;
        check("trap_mepc_final", env_csr[MEPC], ref_csr[MEPC]);
        check("trap_mtvec_final", env_csr[MTVEC], ref_csr[MTVEC]);
`ifdef TRAP_MTVAL_EN
        check("trap_mtval_final", env_csr[MTVAL], ref_csr[MTVAL]);
`endif
        check("trap_no_extra_redirect", redirect_valid, 0);
    endtask

    task automatic do_mret();
        logic [31:0] exp_pc;
        exp_pc = ref_csr[MEPC] & 32'hFFFF_FFFC;
        mret_req = 1'b1;
        ins_valid = 1'b1;
        ins_number = 12'h300;
        ins_access_type = 2'd0;
        #1;
        check("mret_accept_ins_ready", ins_ready, 0);
        check("mret_accept_busy", busy, 0);
        @(negedge clk);
        mret_req = 1'b0;
        ins_valid = 1'b0;
        #1;
        check("mret_c1_busy", busy, 1);
        check("mret_c1_redirect", redirect_valid, 0);
        @(negedge clk);
        #1;
        check("mret_c2_busy", busy, 1);
        check("mret_c2_redirect", redirect_valid, 1);
        check("mret_redirect_pc", redirect_pc, exp_pc);
        @(negedge clk);
        #1;
        check("mret_c3_busy", busy, 0);
        check("mret_c3_redirect", redirect_valid, 0);
    endtask

    initial begin
        logic [31:0] rpc;
        logic [3:0]  rcause;
        int op;
        csr_pool[0] = 12'h300;
        csr_pool[1] = 12'h304;
        csr_pool[2] = MTVEC;
        csr_pool[3] = MEPC;
        csr_pool[4] = MCAUSE;
        csr_pool[5] = MTVAL;
        for (int i = 0; i < 4096; i++) ref_csr[i] = 32'd0;
        reset = 1'b1;
        env_clear = 1'b1;
        trap_req = 1'b0;
        trap_cause = 4'd0;
        trap_pc = 32'd0;
        trap_val = 32'd0;
        mret_req = 1'b0;
        ins_valid = 1'b0;
        ins_number = 12'd0;
        ins_access_type = 2'd0;
        ins_wdata = 32'd0;
        repeat (3) @(negedge clk);
        env_clear = 1'b0;
        reset = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_redirect_valid", redirect_valid, 0);
        check("reset_redirect_pc", redirect_pc, 0);
        check("reset_ins_ready", ins_ready, 0);

        do_ins(MTVEC, 2'd1, 32'h0000_0103);
        do_trap(32'h0000_1006, CAUSE_ILLEGAL_INSTR, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        check("t1_mepc", env_csr[MEPC], 32'h0000_1004);
        check("t1_mcause", env_csr[MCAUSE], 32'd2);

        do_ins(MEPC, 2'd1, 32'h0000_2000);
        do_mret();

        do_trap(32'h0000_3002, CAUSE_BREAKPOINT, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        check("combo_mtvec_kept", env_csr[MTVEC], 32'h0000_0103);

        // Reset during CAUSE_WR; cause matches current mcause so the abandoned write is moot.
        @(negedge clk);
        trap_req = 1'b1;
        trap_pc = 32'h7777_0008;
        trap_cause = ref_csr[MCAUSE][3:0];
        @(negedge clk);
        trap_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_csr[MEPC] = 32'h7777_0008;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_redirect_pc", redirect_pc, 0);
        check("rst_mid_mepc", env_csr[MEPC], ref_csr[MEPC]);
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_no_redirect", redirect_valid, 0);
            @(negedge clk);
            #1;
        end

        do_ins(12'h304, 2'd1, 32'd0);
        do_ins(12'h304, 2'd2, 32'h0000_0888);
        do_ins(12'h304, 2'd0, 32'hFFFF_FFFF);
        check("mie_readback", env_csr[12'h304], 32'h0000_0888);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_ins(csr_pool[$urandom_range(0, 5)], 2'($urandom_range(0, 3)), $urandom);
            end else if (op == 1) begin
                rpc = $urandom;
                case ($urandom_range(0, 2))
                    0: rcause = CAUSE_ILLEGAL_INSTR;
                    1: rcause = CAUSE_BREAKPOINT;
                    default: rcause = CAUSE_ECALL_M;
                endcase
                do_trap(rpc, rcause, $urandom, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                do_mret();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
